// File: rtl/mem_stage_if.sv
// Request/response bus between the stage controller, mem_stage and the data BRAM.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  start;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata_out;
  logic                  busy;
  logic                  done;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic [3:0]            ram_we;
  logic [31:0]           ram_dout;

  // Controller/BRAM side: issues requests and returns BRAM read data.
  modport master (
    output start, mem_read, mem_write, funct3, addr, wdata, ram_dout,
    input  rdata_out, busy, done, fault, ram_addr, ram_din, ram_we
  );

  // Access unit side.
  modport slave (
    input  start, mem_read, mem_write, funct3, addr, wdata, ram_dout,
    output rdata_out, busy, done, fault, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/mem_stage.sv
// MEM-phase data access unit: RV32I loads/stores against a synchronous BRAM
// with byte-lane masking, little-endian lane extraction and sign/zero extension.
module mem_stage #(
  parameter int ADDR_WIDTH  = 15,
  parameter int RAM_LATENCY = 1
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, FINISH} state_t;

  state_t                state;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  fault_q;
  logic [2:0]            lat_cnt;
  logic [31:0]           rdata_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  fault_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [31:0]           ram_din_r;
  logic [3:0]            ram_we_r;

  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        req_fault;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

  // Classify the incoming request and precompute the store lanes/enables.
  always_comb begin
    is_load    = bus.mem_read;
    is_store   = ~bus.mem_read & bus.mem_write;
    misaligned = ((bus.funct3[1:0] == 2'd1) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'd2) && (bus.addr[1:0] != 2'b00));
    req_fault  = 1'b0;
    if (is_load)
      req_fault = misaligned || !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (is_store)
      req_fault = misaligned || !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
    st_mask = 4'b1111;
    st_data = bus.wdata;
    case (bus.funct3[1:0])
      2'd0: begin
        st_mask = 4'b0001 << bus.addr[1:0];
        st_data = {4{bus.wdata[7:0]}};
      end
      2'd1: begin
        st_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = bus.wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the BRAM word and extend it to 32 bits.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.ram_dout[7:0];
      2'd1:    ld_byte = bus.ram_dout[15:8];
      2'd2:    ld_byte = bus.ram_dout[23:16];
      default: ld_byte = bus.ram_dout[31:24];
    endcase
    ld_half = off_q[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
    case (f3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = bus.ram_dout;
    endcase
  end

  // Request FSM; every output is a register so the controller sees clean timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      fault_q    <= 1'b0;
      lat_cnt    <= 3'd0;
      rdata_r    <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fault_r    <= 1'b0;
      ram_addr_r <= '0;
      ram_din_r  <= 32'd0;
      ram_we_r   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          if (bus.start) begin
            busy_r     <= 1'b1;
            f3_q       <= bus.funct3;
            off_q      <= bus.addr[1:0];
            ram_addr_r <= bus.addr[ADDR_WIDTH+1:2];
            fault_q    <= req_fault;
            if (req_fault || (!is_load && !is_store)) begin
              state <= FINISH;
            end else if (is_load) begin
              lat_cnt <= 3'(RAM_LATENCY);
              state   <= READ_WAIT;
            end else begin
              ram_we_r  <= st_mask;
              ram_din_r <= st_data;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          ram_we_r <= 4'd0;
          state    <= FINISH;
        end
        READ_WAIT: begin
          if (lat_cnt == 3'd0) begin
            rdata_r <= ld_value;
            done_r  <= 1'b1;
            fault_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        FINISH: begin
          done_r  <= 1'b1;
          fault_r <= fault_q;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata_out = rdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.fault     = fault_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_din   = ram_din_r;
  assign bus.ram_we    = ram_we_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-array reference model predicts every
// completion and every BRAM write; monitors compare whatever the DUT presents.
module tb_mem_stage;
  localparam int AW    = 6;
  localparam int LAT   = 3;
  localparam int WORDS = 1 << AW;
  localparam int BYTES = 4 * WORDS;

  typedef struct {
    int          lat;
    logic        fault;
    logic [31:0] rdata;
    int          start_cyc;
    int          id;
  } done_exp_t;

  typedef struct {
    logic [AW-1:0] wa;
    logic [3:0]    we;
    logic [31:0]   din;
  } write_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   op_id = 0;

  done_exp_t  dq[$];
  write_exp_t wq[$];

  logic [31:0] ram  [WORDS] = '{default: 32'd0};
  logic [31:0] pipe [LAT]   = '{default: 32'd0};
  logic [7:0]  mdl  [BYTES] = '{default: 8'd0};
  logic [31:0] last_load = 32'd0;

  mem_stage_if #(.ADDR_WIDTH(AW)) bus ();

  mem_stage #(.ADDR_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock and cycle counter used to measure completion latency.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous BRAM with byte enables and LAT-deep read pipeline.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (bus.ram_we[j]) ram[bus.ram_addr][8*j +: 8] <= bus.ram_din[8*j +: 8];
    pipe[0] <= ram[bus.ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_dout = pipe[LAT-1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT presented an event with no expectation queued", nm);
  endtask

  // Monitor: pop and compare on every BRAM write and every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_we != 4'd0) begin
        if (wq.size() == 0) unexpected("write");
        else begin
          write_exp_t w;
          w = wq.pop_front();
          check("ram_we", 32'(bus.ram_we), 32'(w.we));
          check("ram_addr", 32'(bus.ram_addr), 32'(w.wa));
          check("ram_din", bus.ram_din, w.din);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) unexpected("done");
        else begin
          done_exp_t e;
          e = dq.pop_front();
          check($sformatf("latency op%0d", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
          check($sformatf("fault op%0d", e.id), 32'(bus.fault), 32'(e.fault));
          check($sformatf("rdata op%0d", e.id), bus.rdata_out, e.rdata);
          check($sformatf("busy at done op%0d", e.id), 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  // Reference model: predict the outcome of one request, then drive the strobe.
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit commit);
    bit         is_load, is_store, legal, mis, flt;
    int         nb, base;
    longint     v;
    done_exp_t  e;
    write_exp_t w;
    is_load  = rd;
    is_store = !rd && wr;
    nb       = (f3[1:0] == 2'd3) ? 4 : (1 << f3[1:0]);
    base     = int'(a % BYTES);
    mis      = (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
    legal    = is_load ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
    flt      = (is_load || is_store) && (!legal || mis);
    op_id++;
    e.id        = op_id;
    e.fault     = flt;
    e.start_cyc = cyc + 1;
    e.rdata     = last_load;
    if (flt || (!is_load && !is_store)) e.lat = 1;
    else if (is_store) begin
      e.lat  = 2;
      w.wa   = AW'(base / 4);
      w.we   = 4'd0;
      w.din  = 32'd0;
      for (int k = 0; k < nb; k++) w.we = w.we | 4'(1 << ((base + k) % 4));
      for (int j = 0; j < 4; j++) w.din[8*j +: 8] = wd[8*(j % nb) +: 8];
      wq.push_back(w);
      if (commit)
        for (int k = 0; k < nb; k++) mdl[base + k] = wd[8*k +: 8];
    end else begin
      e.lat = LAT + 1;
      v = 0;
      for (int k = 0; k < nb; k++) v = v + (longint'(mdl[base + k]) << (8 * k));
      if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v = v - (longint'(1) << (8 * nb));
      e.rdata = v[31:0];
      if (commit) last_load = v[31:0];
    end
    if (commit) dq.push_back(e);
    bus.start     = 1'b1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("busy after accept op%0d", op_id), 32'(bus.busy), 32'd1);
  endtask

  // Let all outstanding expectations drain, with a bounded wait.
  task automatic wait_idle();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (dq.size() == 0 && wq.size() == 0) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL timeout: %0d completions and %0d writes still pending, expected 0",
             dq.size(), wq.size());
    dq.delete();
    wq.delete();
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    issue(rd, wr, f3, a, wd, 1'b1);
    wait_idle();
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] exp);
    check(nm, bus.rdata_out, exp);
  endtask

  initial begin
    bit          done_seen;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.funct3    = 3'd0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset rdata_out", bus.rdata_out, 32'd0);
    check("reset ram_addr", 32'(bus.ram_addr), 32'd0);
    check("reset ram_din", bus.ram_din, 32'd0);
    check("reset ram_we", 32'(bus.ram_we), 32'd0);
    check("reset busy/done/fault", {29'd0, bus.busy, bus.done, bus.fault}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed loads and stores");
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'd0);
    checkOutput("LB 0x13", 32'hFFFF_FFA5);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'd0);
    checkOutput("LBU 0x13", 32'h0000_00A5);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h8001_7FFF);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'd0);
    checkOutput("LH 0x2", 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'd0);
    checkOutput("LHU 0x2", 32'h0000_8001);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'd0);
    checkOutput("LH 0x0", 32'h0000_7FFF);

    $display("[TB] faults, no-op, read+write, address wrap");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0);
    checkOutput("rdata held over faults", 32'h0000_7FFF);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D);
    checkOutput("read+write acts as LW", 32'hA5AD_BEEF);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'hFFFF_FF10, 32'd0);
    checkOutput("LW wrapped address", 32'hA5AD_BEEF);

    $display("[TB] start while busy and start in done cycle");
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'd0, 1'b1);
    bus.start     = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h0000_0020;
    bus.wdata     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 20 && !done_seen; n++) begin
      @(negedge clk);
      done_seen = bus.done;
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done wait: done=0, expected 1 within 20 cycles");
    end
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_003C, 1'b1);
    wait_idle();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0);
    checkOutput("ignored store left word", 32'h0000_3C00);

    $display("[TB] reset during store");
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h5555_AAAA, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("ram_we after reset", 32'(bus.ram_we), 32'd0);
    check("busy/done after reset", {30'd0, bus.busy, bus.done}, 32'd0);
    check("rdata_out after reset", bus.rdata_out, 32'd0);
    last_load = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'd0);
    checkOutput("aborted store readback", 32'h8001_7FFF);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      if (sel <= 4) begin
        if ($urandom_range(0, 7) != 0) f3 = (f3 inside {3, 6, 7}) ? 3'b010 : f3;
        applyStimulus(1'b1, 1'b0, f3, a, 32'd0);
      end else if (sel <= 8) begin
        if ($urandom_range(0, 7) != 0) f3 = {1'b0, (f3[1:0] == 2'd3) ? 2'd2 : f3[1:0]};
        applyStimulus(1'b0, 1'b1, f3, a, $urandom);
      end else begin
        applyStimulus(sel[0], sel[0], f3, a, $urandom);
      end
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Data-memory access unit for the multi-cycle core's MEM phase.
- Triggered by a one-cycle start strobe from the stage controller during MEM.
- Performs RV32I loads and stores against the synchronous data BRAM: byte-lane masking, little-endian extraction, sign/zero extension.
- Reports completion to the controller before MEM_WB latches the result.

Parameters:
- ADDR_WIDTH, 15, BRAM word-address width (32-bit words).
- RAM_LATENCY, 1, BRAM read latency in clock cycles; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- mem_read  in  1  request is a load.
- mem_write  in  1  request is a store.
- funct3  in  3  access size/sign, RV32I encoding.
- addr  in  32  byte address.
- wdata  in  32  store data (rs2).
- rdata_out  out  32  extended load result.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; misaligned address or illegal funct3.
- ram_addr  out  ADDR_WIDTH  BRAM word address.
- ram_din  out  32  BRAM write data.
- ram_we  out  4  BRAM byte write enables; bit i writes byte lane i.
- ram_dout  in  32  BRAM read data, valid RAM_LATENCY cycles after ram_addr.

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Reset (async): state IDLE; all outputs 0, including rdata_out, ram_addr and ram_din.
- All outputs are registered.
- FSM states: IDLE, WRITE, READ_WAIT, FINISH.
- Edge k means the k-th rising edge after the edge that samples start=1.
- IDLE + start:
  - Capture funct3, addr[1:0], and ram_addr = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap.
  - busy=1 from edge 0.
- Request classification:
  - Load funct3 legal set: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store funct3 legal set: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - mem_read and mem_write both 1: treated as load; store suppressed, no fault.
- Fault or no-op (neither read nor write):
  - Go to FINISH; no BRAM access (ram_we stays 0).
  - Edge 1: done=1, fault = (fault ? 1 : 0), busy=0.
  - rdata_out unchanged.
- Store:
  - Edge 0 -> WRITE: ram_we = mask for exactly one cycle.
  - ram_din lanes: SB replicates wdata[7:0] x4; SH replicates wdata[15:0] x2; SW = wdata.
  - Masks: SB 0001<<addr[1:0]; SH 0011 (addr[1]=0) or 1100; SW 1111.
  - Edge 1 -> FINISH: ram_we=0. Edge 2: done=1, busy=0.
- Load:
  - Edge 0 -> READ_WAIT; latency counter loaded with RAM_LATENCY.
  - At edge RAM_LATENCY+1: capture ram_dout.
  - Select lane by addr[1:0] (byte) or addr[1] (half); sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Write rdata_out; done=1 in the same cycle; busy=0.
- Completion: done is high exactly one cycle; state returns to IDLE on the next edge.
- rdata_out holds its last load value through stores, faults and idle.
- start while busy: ignored; no queueing.
- start in the done cycle: accepted, because the state is already IDLE when done is visible.
- Reset mid-operation: aborts immediately; ram_we drops to 0 asynchronously, so no partial store completes after reset asserts.

Test Plan:
- Reset, then SW addr=0x10, wdata=0xDEADBEEF -> edge1: ram_addr=4, ram_we=1111, ram_din=0xDEADBEEF; edge2: done=1, fault=0.
- SB addr=0x13, wdata=0x000000A5 -> ram_we=1000, ram_din=0xA5A5A5A5; then LB addr=0x13 -> rdata_out=0xFFFFFFA5; LBU addr=0x13 -> 0x000000A5; done at edge 2 (RAM_LATENCY=1).
- Word 0x8001_7FFF at word address 0: LH addr=0x2 -> 0xFFFF8001; LHU addr=0x2 -> 0x00008001; LH addr=0x0 -> 0x00007FFF.
- LW addr=0x6 and SH addr=0x1 -> edge1: done=1, fault=1, ram_we never nonzero, rdata_out unchanged; funct3=011 load -> fault=1.
- RAM_LATENCY=3 build, LW -> done at edge 4. A second start pulsed at edge 2 is ignored; a start in the done cycle is accepted.
- Assert reset during WRITE cycle of SW -> ram_we=0 immediately; busy=0, done=0, state IDLE; a memory readback shows the old value.
